// File: rtl/gcd_scheduler.sv
`timescale 1ns/1ps
// gcd_scheduler: round-robin arbiter and sequencer that shares one
// subtractive-GCD datapath between NREQ requesters.
//   clk, rst_n           clock, async active-low reset
//   req/opa/opb -> gnt   per-requester operand pairs, one-hot grant pulse
//   rsp_*                valid/ready result port (id, data, watchdog err)
//   busy                 high whenever the FSM is not IDLE
//   dp_data_in, ldA, ldB, sel, sel_in -> datapath controls
//   lt, gt, eq, dp_result <- datapath compare flags and A register
// Optional: define GCD_SCHED_WATCHDOG_EN to abort after MAX_ITER CMP cycles.
module gcd_scheduler #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 16,
    parameter int MAX_ITER = 65536
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   opa,
    input  logic [NREQ*WIDTH-1:0]   opb,
    output logic [NREQ-1:0]         gnt,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]        rsp_data,
    output logic                    rsp_err,
    output logic                    busy,
    output logic [WIDTH-1:0]        dp_data_in,
    output logic                    ldA,
    output logic                    ldB,
    output logic                    sel,
    output logic                    sel_in,
    input  logic                    lt,
    input  logic                    gt,
    input  logic                    eq,
    input  logic [WIDTH-1:0]        dp_result
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [2:0] {
        IDLE,
        LOADA,
        LOADB,
        CMP,
        RESP
    } state_t;

    state_t           state;
    state_t           nstate;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   ptr_nx;
    logic [IDW-1:0]   pick;
    logic [IDW-1:0]   idx;
    logic             found;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic             op_zero;
    logic             wd_hit;
    int               j;

    // First asserted request at or after ptr, wrapping modulo NREQ.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            idx = IDW'(j);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick == IDW'(k)) begin
                a_sel = opa[k*WIDTH +: WIDTH];
                b_sel = opb[k*WIDTH +: WIDTH];
            end
        end
    end

    assign op_zero = (a_q == '0) || (b_q == '0);
    assign ptr_nx  = (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
    assign busy    = (state != IDLE);

    // A pending gnt pulse in IDLE marks the cycle right after capture;
    // the FSM launches from there so gnt itself can stay registered.
    always_comb begin
        nstate     = state;
        ldA        = 1'b0;
        ldB        = 1'b0;
        sel        = 1'b0;
        sel_in     = 1'b0;
        dp_data_in = '0;
        unique case (state)
            IDLE: begin
                if (|gnt) nstate = op_zero ? RESP : LOADA;
            end
            LOADA: begin
                dp_data_in = a_q;
                sel_in     = 1'b1;
                ldA        = 1'b1;
                nstate     = LOADB;
            end
            LOADB: begin
                dp_data_in = b_q;
                sel_in     = 1'b1;
                ldB        = 1'b1;
                nstate     = CMP;
            end
            CMP: begin
                if (eq) begin
                    nstate = RESP;
                end else if (wd_hit) begin
                    nstate = RESP;
                end else if (lt) begin
                    sel = 1'b1;
                    ldB = 1'b1;
                end else if (gt) begin
                    ldA = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state <= nstate;
            gnt   <= '0;
            unique case (state)
                IDLE: begin
                    if (|gnt) begin
                        if (op_zero) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= a_q | b_q;
                        end
                    end else if (found) begin
                        gnt[pick] <= 1'b1;
                        a_q       <= a_sel;
                        b_q       <= b_sel;
                        rsp_id    <= pick;
                    end
                end
                CMP: begin
                    if (eq) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= dp_result;
                    end else if (wd_hit) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= '0;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= ptr_nx;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef GCD_SCHED_WATCHDOG_EN
    logic [WIDTH:0] iter;

    assign wd_hit = (iter == (WIDTH+1)'(MAX_ITER));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter    <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (state == LOADB) iter <= '0;
            else if (state == CMP) iter <= iter + 1'b1;
            if (state == CMP && !eq && wd_hit) rsp_err <= 1'b1;
            else if (state == RESP && rsp_ready) rsp_err <= 1'b0;
        end
    end
`else
    logic unused_max_iter;

    assign wd_hit          = 1'b0;
    assign rsp_err         = 1'b0;
    assign unused_max_iter = (MAX_ITER != 0);
`endif

endmodule
